// File: rtl/netdma_channel_arbiter_if.sv
// Channel-side and engine-side signals of the netdma channel arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface netdma_channel_arbiter_if #(
  parameter int CH_NUM = 4
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic [CH_NUM-1:0] ch_empty_i;
  logic [CH_NUM-1:0] ch_enable_i;
  logic [CH_NUM-1:0] ch_rdreq_o;
  logic              engine_fifo_empty_o;
  logic              engine_go_o;
  logic              engine_rdreq_i;
  logic [CH_W-1:0]   grant_o;
  logic              grant_valid_o;
  logic              protocol_err_o;

  modport master (
    input  ch_empty_i,
    input  ch_enable_i,
    input  engine_rdreq_i,
    output ch_rdreq_o,
    output engine_fifo_empty_o,
    output engine_go_o,
    output grant_o,
    output grant_valid_o,
    output protocol_err_o
  );

  modport slave (
    output ch_empty_i,
    output ch_enable_i,
    output engine_rdreq_i,
    input  ch_rdreq_o,
    input  engine_fifo_empty_o,
    input  engine_go_o,
    input  grant_o,
    input  grant_valid_o,
    input  protocol_err_o
  );
endinterface

// File: rtl/netdma_channel_arbiter.sv
// Round-robin arbiter sharing one netdma dispatcher engine between CH_NUM
// descriptor queues, with a per-grant burst budget and a REARB bubble per descriptor.
module netdma_channel_arbiter #(
  parameter int CH_NUM    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  netdma_channel_arbiter_if.master bus
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_BURST);
  localparam logic [CH_W-1:0] LAST_INIT = CH_W'(CH_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_REARB
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic              perr_q, perr_d;

  logic [CH_NUM-1:0] eligible;
  logic              any_eligible;
  logic [CH_W-1:0]   rr_base;
  logic [CH_W-1:0]   rr_next;
  logic [CH_NUM-1:0] ch_rdreq;
  logic              engine_go;
  logic              engine_fifo_empty;
  logic              grant_valid;

  // First eligible channel after 'last', wrapping; 'last' itself is the final candidate.
  function automatic logic [CH_W-1:0] rr_pick(input logic [CH_W-1:0]   last,
                                              input logic [CH_NUM-1:0] elig);
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] cand;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int off = 1; off <= CH_NUM; off++) begin
      cand = CH_W'((int'(last) + off) % CH_NUM);
      if (!found && elig[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign eligible     = bus.ch_enable_i & ~bus.ch_empty_i;
  assign any_eligible = |eligible;
  // In REARB the just-served grant becomes the new search origin.
  assign rr_base      = (state_q == S_REARB) ? grant_q : last_q;
  assign rr_next      = rr_pick(rr_base, eligible);

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_d            = last_q;
    burst_cnt_d       = burst_cnt_q;
    perr_d            = perr_q;
    ch_rdreq          = '0;
    engine_go         = 1'b0;
    engine_fifo_empty = 1'b1;
    grant_valid       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.engine_rdreq_i) begin
          perr_d = 1'b1;
        end
        if (any_eligible) begin
          grant_d     = rr_next;
          burst_cnt_d = '0;
          state_d     = S_BUSY;
        end
      end

      S_BUSY: begin
        grant_valid       = 1'b1;
        engine_go         = 1'b1;
        engine_fifo_empty = bus.ch_empty_i[grant_q];
        if (bus.engine_rdreq_i) begin
          ch_rdreq[grant_q] = 1'b1;
          if (burst_cnt_q != BURST_MAX) begin
            burst_cnt_d = burst_cnt_q + BC_W'(1);
          end
          state_d = S_REARB;
        end
      end

      S_REARB: begin
        if (bus.engine_rdreq_i) begin
          perr_d = 1'b1;
        end
        if ((burst_cnt_q < BURST_MAX) && eligible[grant_q]) begin
          state_d = S_BUSY;
        end else begin
          last_d      = grant_q;
          burst_cnt_d = '0;
          if (any_eligible) begin
            grant_d = rr_next;
            state_d = S_BUSY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_q      <= LAST_INIT;
      burst_cnt_q <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      perr_q      <= perr_d;
    end
  end

  assign bus.ch_rdreq_o          = ch_rdreq;
  assign bus.engine_go_o         = engine_go;
  assign bus.engine_fifo_empty_o = engine_fifo_empty;
  assign bus.grant_o             = grant_q;
  assign bus.grant_valid_o       = grant_valid;
  assign bus.protocol_err_o      = perr_q;

endmodule

// File: doc/netdma_channel_arbiter.md
Name: netdma_channel_arbiter

Overview:
- Shares one netdma dispatcher engine (descriptor control FSM plus read/write masters) between CH_NUM descriptor queues, e.g. several TX rings.
- Grants the engine to one channel at a time, round-robin, with an optional per-grant burst budget.
- Presents the granted channel's FIFO status and a go strobe to the engine's control FSM.
- Routes the engine's descriptor-retire pulse back to the granted channel's FIFO as a read request.

Parameters:
- CH_NUM, 4: number of descriptor queues; minimum 2.
- MAX_BURST, 4: maximum descriptors retired per grant before forced rotation; minimum 1.
- CH_W, $clog2(CH_NUM): width of grant index (derived).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  synchronous reset, active-low.
- ch_empty_i  in  CH_NUM  per-channel descriptor FIFO empty flag (show-ahead FIFO).
- ch_enable_i  in  CH_NUM  per-channel software enable.
- ch_rdreq_o  out  CH_NUM  one-hot pop of the granted channel's FIFO.
- engine_fifo_empty_o  out  1  empty flag presented to the engine control FSM.
- engine_go_o  out  1  go/enable to the engine control FSM.
- engine_rdreq_i  in  1  engine retire pulse: descriptor done (eop or error).
- grant_o  out  CH_W  index of the current or last granted channel.
- grant_valid_o  out  1  engine currently owned by grant_o.
- protocol_err_o  out  1  sticky error: engine_rdreq_i seen outside BUSY.

Behaviour:
- All state is updated on the rising edge of clk_i.
- When rst_n_i=0 at a clock edge, the block enters IDLE and clears grant_o, grant_valid_o, burst_cnt and protocol_err_o.
  - The last-served pointer is set to CH_NUM-1, so channel 0 wins the first arbitration.
  - Reset applies regardless of state, including mid-descriptor. Resetting the engine is the system's responsibility.
- Output values in IDLE/after reset: engine_go_o=0, engine_fifo_empty_o=1, ch_rdreq_o=0.
- Eligible channel: ch_enable_i[i]=1 and ch_empty_i[i]=0.
- States: IDLE, BUSY, REARB.
- IDLE:
  - engine_go_o=0, engine_fifo_empty_o=1.
  - If any channel is eligible: grant = first eligible channel searching from last+1 with wrap; burst_cnt=0; go to BUSY next cycle.
- BUSY:
  - grant_valid_o=1, engine_go_o=1, engine_fifo_empty_o=ch_empty_i[grant] (combinational).
  - On engine_rdreq_i=1: ch_rdreq_o[grant]=1 in the same cycle (zero latency), burst_cnt increments, next state is REARB.
  - No other exit from BUSY. Clearing ch_enable_i of the granted channel never aborts the descriptor in progress.
- REARB (one cycle):
  - engine_go_o=0, engine_fifo_empty_o=1, grant_valid_o=0.
  - This bubble covers the engine's DONE cycle and the FIFO's one-cycle empty-flag update after a pop.
  - Sticky: if burst_cnt<MAX_BURST and the granted channel is still eligible, keep the grant and return to BUSY.
  - Otherwise: last=grant; pick the next eligible channel from last+1 with wrap; burst_cnt=0; go to BUSY.
  - If no channel is eligible, go to IDLE.
- burst_cnt width is $clog2(MAX_BURST+1) and it never wraps. With MAX_BURST=1, the block rotates after every descriptor.
- Round-robin search includes the just-served channel as the last candidate. A single active channel therefore re-wins after REARB.
- engine_rdreq_i in IDLE or REARB: ignored (no pop, no state change) and sets protocol_err_o, which is cleared only by reset.
- ch_rdreq_o is never asserted for more than one channel and never outside BUSY.
- grant_o holds its value in IDLE/REARB for debug/status reads.
- Throughput: one idle cycle (REARB) per retired descriptor.
- Latency: 1 cycle from a channel becoming eligible in IDLE to engine_go_o=1.

Test Plan:
- Reset, then ch0 has 1 descriptor, enable=4'b1111.
  - Cycle after eligibility: grant_o=0, engine_go_o=1, engine_fifo_empty_o=0.
  - On engine_rdreq_i pulse: ch_rdreq_o=4'b0001 in the same cycle, then REARB, then IDLE (ch0 now empty).
- All 4 channels hold 10 descriptors, MAX_BURST=4, 20 retire pulses.
  - Required grant sequence: 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0.
  - REARB gap of exactly 1 cycle (go=0) between consecutive pulses.
- ch1 only eligible, 6 descriptors, MAX_BURST=2: grant stays 1 for all 6 pulses across rotations; never idles between descriptors.
- Clear ch_enable_i[2] while channel 2 is BUSY mid-descriptor.
  - The descriptor completes and ch_rdreq_o[2] pulses.
  - At REARB, grant moves to channel 3 even though burst_cnt=1<MAX_BURST.
- Pulse engine_rdreq_i while in IDLE: ch_rdreq_o stays 0, state stays IDLE, protocol_err_o=1 until rst_n_i=0.
- Assert rst_n_i=0 for one cycle while BUSY on channel 3.
  - Next cycle: IDLE, grant_o=0, engine_go_o=0.
  - With all channels eligible, the next grant is channel 0.
